// File: rtl/decomp_pkg.sv
// Shared definitions for the decompression output packer: beat geometry,
// packer state encoding and the byte-enable helper.
package decomp_pkg;

   localparam int unsigned BEAT_BYTES = 32;
   localparam int unsigned BEAT_BITS  = 8 * BEAT_BYTES;

   typedef enum logic {
      StFill  = 1'b0,
      StDrain = 1'b1
   } packer_state_e;

   // (1 << len) - 1 over BEAT_BYTES lanes; len >= BEAT_BYTES gives all ones.
   function automatic logic [BEAT_BYTES-1:0] keep_from_len(input logic [6:0] len);
      logic [BEAT_BYTES:0] one_hot;
      one_hot = {{BEAT_BYTES{1'b0}}, 1'b1} << len;
      return one_hot[BEAT_BYTES-1:0] - {{(BEAT_BYTES-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/decomp_byte_shifter.sv
// Combinational byte-granular left shift of one 32-byte chunk into the
// 64-byte accumulation window. Offsets of 64 push the chunk out entirely.
module decomp_byte_shifter
   import decomp_pkg::*;
(
   input  logic [BEAT_BITS-1:0]   chunk_i,
   input  logic [6:0]             offset_i,
   output logic [2*BEAT_BITS-1:0] shifted_o
);

   logic [2*BEAT_BITS-1:0] wide;

   // Zero-extend the chunk and move it up by offset_i whole bytes.
   always_comb begin
      wide      = {{BEAT_BITS{1'b0}}, chunk_i};
      shifted_o = wide << {offset_i, 3'b000};
   end

endmodule

// File: rtl/decomp_out_packer.sv
// Final stage of the 256-bit decompression pipeline. Repacks 0..32-byte
// chunks into dense 32-byte AXI4-Stream c2s beats; only the last beat of a
// packet carries a partial tkeep.
// Optional feature macro: DECOMP_PACKER_BYTECOUNT_EN adds pkt_bytes/pkt_done,
// reporting the kept-byte total of each completed packet.
module decomp_out_packer
   import decomp_pkg::*;
#(
   parameter int unsigned DATA_BYTES = 32,
   parameter int unsigned LVL_W      = 7
) (
   input  logic                      axis_aclk,
   input  logic                      axis_areset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [8*DATA_BYTES-1:0]   in_data,
   input  logic [5:0]                in_bytes,
   input  logic                      in_last,
   output logic [8*DATA_BYTES-1:0]   axis_tdata_c2s,
   output logic [DATA_BYTES-1:0]     axis_tkeep_c2s,
   output logic                      axis_tvalid_c2s,
   output logic                      axis_tlast_c2s,
   input  logic                      axis_tready_c2s,
`ifdef DECOMP_PACKER_BYTECOUNT_EN
   output logic [31:0]               pkt_bytes,
   output logic                      pkt_done,
`endif
   output logic                      err_len
);

   localparam logic [LVL_W-1:0] BeatLvl = LVL_W'(BEAT_BYTES);
   localparam logic [5:0]       MaxIn   = 6'(BEAT_BYTES);

   // Registered state: two beats of storage, fill level, packer phase.
   packer_state_e            state_q, state_d;
   logic [LVL_W-1:0]         lvl_q, lvl_d;
   logic [2*BEAT_BITS-1:0]   buf_q, buf_d;
   logic                     err_len_q, err_len_d;

   // Combinational helpers.
   logic                     out_valid;
   logic [DATA_BYTES-1:0]    out_keep;
   logic                     out_last;
   logic                     pop;
   logic                     push;
   logic                     len_over;
   logic [LVL_W-1:0]         chunk_len;
   logic [DATA_BYTES-1:0]    chunk_keep;
   logic [8*DATA_BYTES-1:0]  chunk_masked;
   logic [2*BEAT_BITS-1:0]   base_buf;
   logic [LVL_W-1:0]         base_lvl;
   logic [2*BEAT_BITS-1:0]   chunk_shifted;

   // Beat presentation and input acceptance, all derived from registered state.
   always_comb begin
      out_valid = 1'b0;
      out_keep  = '0;
      out_last  = 1'b0;
      in_ready  = 1'b0;
      if (state_q == StFill) begin
         out_valid = (lvl_q >= BeatLvl);
         out_keep  = out_valid ? '1 : '0;
         // Gated by reset so no chunk is accepted while the block is held.
         in_ready  = (lvl_q <= BeatLvl) && !axis_areset;
      end else begin
         out_valid = 1'b1;
         if (lvl_q > BeatLvl) begin
            out_keep = '1;
         end else begin
            out_keep = keep_from_len(7'(lvl_q));
            out_last = 1'b1;
         end
      end
   end

   // Drive c2s data with unkept lanes forced to zero.
   always_comb begin
      axis_tdata_c2s = '0;
      for (int k = 0; k < DATA_BYTES; k++) begin
         axis_tdata_c2s[8*k +: 8] = out_keep[k] ? buf_q[8*k +: 8] : 8'h00;
      end
   end

   assign axis_tvalid_c2s = out_valid;
   assign axis_tkeep_c2s  = out_keep;
   assign axis_tlast_c2s  = out_last;
   assign err_len         = err_len_q;

   assign pop      = out_valid && axis_tready_c2s;
   assign push     = in_valid && in_ready;
   assign len_over = (in_bytes > MaxIn);

   // Saturate the byte count and clear lanes past it so the buffer stays zero above L.
   always_comb begin
      chunk_len    = len_over ? BeatLvl : LVL_W'(in_bytes);
      chunk_keep   = keep_from_len(7'(chunk_len));
      chunk_masked = '0;
      for (int k = 0; k < DATA_BYTES; k++) begin
         chunk_masked[8*k +: 8] = chunk_keep[k] ? in_data[8*k +: 8] : 8'h00;
      end
   end

   // Buffer and level after this cycle's pop, before any push lands.
   always_comb begin
      base_buf = buf_q;
      base_lvl = lvl_q;
      if (pop) begin
         if (out_last) begin
            base_buf = '0;
            base_lvl = '0;
         end else begin
            base_buf = buf_q >> BEAT_BITS;
            base_lvl = lvl_q - BeatLvl;
         end
      end
   end

   decomp_byte_shifter u_shifter (
      .chunk_i   (chunk_masked),
      .offset_i  (7'(base_lvl)),
      .shifted_o (chunk_shifted)
   );

   // Next-state: merge the shifted chunk above the surviving bytes.
   always_comb begin
      state_d   = state_q;
      buf_d     = base_buf;
      lvl_d     = base_lvl;
      err_len_d = err_len_q;
      if (pop && out_last) begin
         state_d = StFill;
      end
      if (push) begin
         buf_d = base_buf | chunk_shifted;
         lvl_d = base_lvl + chunk_len;
         if (len_over) begin
            err_len_d = 1'b1;
         end
         if (in_last) begin
            state_d = StDrain;
         end
      end
   end

   // State register with synchronous reset; reset drops any buffered bytes.
   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         state_q   <= StFill;
         lvl_q     <= '0;
         buf_q     <= '0;
         err_len_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lvl_q     <= lvl_d;
         buf_q     <= buf_d;
         err_len_q <= err_len_d;
      end
   end

`ifdef DECOMP_PACKER_BYTECOUNT_EN
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] pkt_bytes_q, pkt_bytes_d;
   logic        pkt_done_q, pkt_done_d;
   logic [31:0] beat_kept;

   // Accumulate kept bytes per popped beat; publish the total on the tlast pop.
   always_comb begin
      beat_kept   = out_last ? 32'(lvl_q) : 32'(BEAT_BYTES);
      cnt_d       = cnt_q;
      pkt_bytes_d = pkt_bytes_q;
      pkt_done_d  = 1'b0;
      if (pop) begin
         if (out_last) begin
            pkt_bytes_d = cnt_q + beat_kept;
            cnt_d       = '0;
            pkt_done_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + beat_kept;
         end
      end
   end

   // Byte-count registers, cleared with the rest of the block.
   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         cnt_q       <= '0;
         pkt_bytes_q <= '0;
         pkt_done_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         pkt_bytes_q <= pkt_bytes_d;
         pkt_done_q  <= pkt_done_d;
      end
   end

   assign pkt_bytes = pkt_bytes_q;
   assign pkt_done  = pkt_done_q;
`else
   // Byte counter not built.
`endif

endmodule

// File: tb/tb_decomp_out_packer.sv
// Bench for decomp_out_packer: table of packets with hand-computed beat
// counts and final tkeep, a byte-queue model checked every cycle, and
// hand-written reset sequences.
`timescale 1ns/1ps
module tb_decomp_out_packer;

   logic         axis_aclk = 1'b0;
   logic         axis_areset;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] in_data;
   logic [5:0]   in_bytes;
   logic         in_last;
   logic [255:0] axis_tdata_c2s;
   logic [31:0]  axis_tkeep_c2s;
   logic         axis_tvalid_c2s;
   logic         axis_tlast_c2s;
   logic         axis_tready_c2s;
   logic         err_len;
`ifdef DECOMP_PACKER_BYTECOUNT_EN
   logic [31:0]  pkt_bytes;
   logic         pkt_done;
`endif

   decomp_out_packer dut (
      .axis_aclk       (axis_aclk),
      .axis_areset     (axis_areset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .in_bytes        (in_bytes),
      .in_last         (in_last),
      .axis_tdata_c2s  (axis_tdata_c2s),
      .axis_tkeep_c2s  (axis_tkeep_c2s),
      .axis_tvalid_c2s (axis_tvalid_c2s),
      .axis_tlast_c2s  (axis_tlast_c2s),
      .axis_tready_c2s (axis_tready_c2s),
`ifdef DECOMP_PACKER_BYTECOUNT_EN
      .pkt_bytes       (pkt_bytes),
      .pkt_done        (pkt_done),
`endif
      .err_len         (err_len)
   );

   always #5 axis_aclk = ~axis_aclk;

   typedef struct {
      int          nchunks;
      int          raw;
      bit          tog;
      int          exp_beats;
      logic [31:0] exp_last_keep;
      bit          exp_err;
      int          exp_ticks;
      int          exp_bytes;
   } vec_t;

   vec_t        vecs[7];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   bit          tog_mode = 1'b0;
   logic [3:0]  tog_pat = 4'b1001;
   logic [7:0]  seq = 8'h00;
   logic [7:0]  q[$];
   bit          m_drain = 1'b0;
   bit          m_err = 1'b0;
   bit          accepted;
   bit          seen_last;
   int          beats;
   logic [31:0] last_keep;
   int          acc_ticks;
   int          done_cnt;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One clock: drive tready, compare against the model at negedge, advance model.
   task automatic tick();
      bit          exp_valid, exp_ready, exp_lastb;
      int          kept, n;
      logic [31:0] exp_keep;
      logic [255:0] exp_data;
      axis_tready_c2s = tog_mode ? tog_pat[cyc % 4] : 1'b1;
      cyc++;
      @(negedge axis_aclk);
      accepted = 1'b0;
`ifdef DECOMP_PACKER_BYTECOUNT_EN
      if (pkt_done) done_cnt++;
`endif
      if (axis_areset) begin
         check("ready_in_reset", 256'(in_ready), 256'(0));
         q.delete();
         m_drain = 1'b0;
         m_err = 1'b0;
      end else begin
         exp_valid = m_drain || (q.size() >= 32);
         exp_ready = !m_drain && (q.size() <= 32);
         exp_lastb = m_drain && (q.size() <= 32);
         kept = exp_lastb ? q.size() : 32;
         exp_keep = (kept >= 32) ? 32'hFFFF_FFFF : ((32'd1 << kept) - 32'd1);
         exp_data = '0;
         if (!exp_valid) begin
            exp_keep = '0;
         end else begin
            for (int k = 0; k < kept; k++) exp_data[8*k +: 8] = q[k];
         end
         check("tvalid", 256'(axis_tvalid_c2s), 256'(exp_valid));
         check("in_ready", 256'(in_ready), 256'(exp_ready));
         check("tkeep", 256'(axis_tkeep_c2s), 256'(exp_keep));
         check("tlast", 256'(axis_tlast_c2s), 256'(exp_valid && exp_lastb));
         check("tdata", axis_tdata_c2s, exp_data);
         check("err_len", 256'(err_len), 256'(m_err));
         if (exp_valid && axis_tready_c2s) begin
            for (int k = 0; k < kept; k++) void'(q.pop_front());
            beats++;
            if (exp_lastb) begin
               m_drain = 1'b0;
               seen_last = 1'b1;
               last_keep = exp_keep;
            end
         end
         if (in_valid && in_ready) begin
            n = (int'(in_bytes) > 32) ? 32 : int'(in_bytes);
            for (int k = 0; k < n; k++) q.push_back(in_data[8*k +: 8]);
            if (int'(in_bytes) > 32) m_err = 1'b1;
            if (in_last) m_drain = 1'b1;
            accepted = 1'b1;
         end
      end
      @(posedge axis_aclk);
      #1;
   endtask

   task automatic send_chunk(input int raw, input bit last);
      int n;
      n = (raw > 32) ? 32 : raw;
      for (int k = 0; k < 32; k++) in_data[8*k +: 8] = (k < n) ? seq + 8'(k) : 8'hEE;
      in_bytes = 6'(raw);
      in_last  = last;
      in_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         tick();
         acc_ticks++;
         if (accepted) break;
      end
      if (!accepted) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
      end
      seq = seq + 8'(n);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && !seen_last; t++) tick();
      check("drain_saw_tlast", 256'(seen_last), 256'(1));
   endtask

   initial begin
      vecs[0] = '{4, 10, 1'b0, 2, 32'h0000_00FF, 1'b0, 4, 40};
      vecs[1] = '{8, 32, 1'b0, 8, 32'hFFFF_FFFF, 1'b0, 8, 256};
      vecs[2] = '{8, 32, 1'b1, 8, 32'hFFFF_FFFF, 1'b0, -1, 256};
      vecs[3] = '{5, 7, 1'b1, 2, 32'h0000_0007, 1'b0, -1, 35};
      vecs[4] = '{3, 20, 1'b0, 2, 32'h0FFF_FFFF, 1'b0, -1, 60};
      vecs[5] = '{1, 0, 1'b0, 1, 32'h0000_0000, 1'b0, 1, 0};
      vecs[6] = '{1, 40, 1'b0, 1, 32'hFFFF_FFFF, 1'b1, 1, 32};

      axis_areset = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_bytes = '0;
      in_last = 1'b0;
      axis_tready_c2s = 1'b1;
      tick();
      tick();
      axis_areset = 1'b0;
      #1;
      check("rst_tvalid", 256'(axis_tvalid_c2s), 256'(0));
      check("rst_tkeep", 256'(axis_tkeep_c2s), 256'(0));
      check("rst_tlast", 256'(axis_tlast_c2s), 256'(0));
      check("rst_tdata", axis_tdata_c2s, 256'(0));
      check("rst_err_len", 256'(err_len), 256'(0));
      check("rst_in_ready", 256'(in_ready), 256'(1));

      foreach (vecs[i]) begin
         tog_mode = vecs[i].tog;
         seen_last = 1'b0;
         beats = 0;
         last_keep = 32'hDEAD_BEEF;
         acc_ticks = 0;
         for (int c = 0; c < vecs[i].nchunks; c++) begin
            send_chunk(vecs[i].raw, c == vecs[i].nchunks - 1);
         end
         if (vecs[i].exp_ticks >= 0) begin
            check($sformatf("v%0d_accept_ticks", i), 256'(acc_ticks), 256'(vecs[i].exp_ticks));
         end
         drain();
         check($sformatf("v%0d_beats", i), 256'(beats), 256'(vecs[i].exp_beats));
         check($sformatf("v%0d_last_keep", i), 256'(last_keep), 256'(vecs[i].exp_last_keep));
         check($sformatf("v%0d_err_len", i), 256'(err_len), 256'(vecs[i].exp_err));
`ifdef DECOMP_PACKER_BYTECOUNT_EN
         check($sformatf("v%0d_pkt_bytes", i), 256'(pkt_bytes), 256'(vecs[i].exp_bytes));
`endif
      end

      // Mid-packet reset with 20 bytes buffered, then a fresh 5-byte packet.
      tog_mode = 1'b0;
      send_chunk(20, 1'b0);
      tick();
      axis_areset = 1'b1;
      tick();
      axis_areset = 1'b0;
      #1;
      check("mid_rst_tvalid", 256'(axis_tvalid_c2s), 256'(0));
      check("mid_rst_in_ready", 256'(in_ready), 256'(1));
      check("mid_rst_err_len", 256'(err_len), 256'(0));
`ifdef DECOMP_PACKER_BYTECOUNT_EN
      check("mid_rst_pkt_bytes", 256'(pkt_bytes), 256'(0));
`endif
      done_cnt = 0;
      seen_last = 1'b0;
      beats = 0;
      last_keep = 32'hDEAD_BEEF;
      send_chunk(0, 1'b0);
      send_chunk(5, 1'b1);
      drain();
      check("post_rst_beats", 256'(beats), 256'(1));
      check("post_rst_last_keep", 256'(last_keep), 256'(32'h0000_001F));
      tick();
      tick();
`ifdef DECOMP_PACKER_BYTECOUNT_EN
      check("post_rst_pkt_bytes", 256'(pkt_bytes), 256'(5));
      check("post_rst_pkt_done_pulses", 256'(done_cnt), 256'(1));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
